mux5_rr_arbiter: RTL and testbench
==================================

// Module: mux5_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 32-bit mux5x1 result path among 5 requesters.
//  Drives the 3-bit mux select and a one-hot grant; supports locked multi-beat
//  ownership with a starvation guard. Sits beside the shared mux in the RISC-V
//  datapath; consumer accepts beats via READY.
// PARAMETERS
//  MAX_HOLD     8       max consecutive accepted beats one locked owner may take (>=1)
//  DEFAULT_SEL  3'b000  SELECT value when no grant is active
// PORTS
//  CLK      in   1  clock, rising edge
//  RESET    in   1  asynchronous, active-low reset
//  REQ      in   5  per-requester request; REQ[i] selects mux input in(i+1)
//  LOCK     in   5  per-requester: keep ownership after current beat
//  READY    in   1  consumer accepts the current beat this cycle
//  GNT      out  5  one-hot grant, registered
//  SELECT   out  3  mux select = binary index of granted requester (0..4)
//  VALID    out  1  a grant is active; the beat on the mux output is valid
// BEHAVIOUR
//  Reset (RESET=0, async): GNT=0, SELECT=DEFAULT_SEL, VALID=0, state=IDLE,
//   rr pointer=4 (requester 0 wins first), hold counter=0.
//  All outputs registered; SELECT/GNT/VALID change only on CLK rising edge.
//  SELECT never takes 3'b101..3'b111. GNT is one-hot or zero; VALID == |GNT.
//  Winner = first i with REQ[i]=1 searching (ptr+1)..(ptr+5) mod 5.
//  States:
//   IDLE : no REQ -> IDLE. Any REQ -> GRANT next edge: GNT=winner, SELECT=idx,
//          VALID=1, ptr=idx, hold=0. Latency REQ->VALID = 1 cycle.
//   GRANT: owner o.
//    - REQ[o]=0 (abort): release at this edge regardless of READY; regrant per
//      rule below.
//    - REQ[o]=1, READY=0: hold all outputs; hold counter unchanged.
//    - REQ[o]=1, READY=1 (beat accepted): hold=hold+1.
//        stay if LOCK[o]=1 and hold+1 < MAX_HOLD; else release.
//  Release: if any REQ[j] with j!=o, grant the rr winner next cycle with no idle
//   gap (ptr=o so o is last); else if REQ[o] still 1, re-grant o;
//   else -> IDLE (GNT=0, VALID=0, SELECT=DEFAULT_SEL).
//  Each new grant resets hold to 0. Changes to REQ/LOCK of non-owners are ignored
//   during GRANT.
//  MAX_HOLD=1: lock ineffective; ownership rotates every accepted beat.
//  Reset mid-GRANT: outputs clear immediately; beat in flight is dropped.
// TESTING
//  1 Reset: RESET=0 with REQ=5'b11111 -> GNT=0, VALID=0, SELECT=000;
//    release, next edge -> GNT=00001, SELECT=000.
//  2 Fairness: REQ=5'b11111, LOCK=0, READY=1 constant -> SELECT sequence
//    0,1,2,3,4,0 on consecutive cycles, VALID held 1.
//  3 Backpressure: single REQ[3], READY=0 for 4 cycles -> GNT=01000, SELECT=011
//    stable; READY=1 one cycle, REQ[3] drops -> VALID=0 next cycle.
//  4 Lock + guard: REQ=5'b00101, LOCK[0]=1, READY=1, MAX_HOLD=8 -> requester 0
//    holds exactly 8 beats, then SELECT=010 with no idle cycle.
//  5 Abort: owner 2 drops REQ[2] while READY=0, REQ[4]=1 -> next edge
//    GNT=10000, SELECT=100.
//  6 Async reset mid-GRANT: RESET low between edges -> GNT/VALID clear before
//    next CLK edge; rr pointer back to 4.

Source files
------------

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter for a 5-input shared 32-bit result mux: one-hot grant, mux select
// and valid, with locked multi-beat ownership bounded by MAX_HOLD accepted beats.
module mux5_rr_arbiter #(
  parameter int unsigned MAX_HOLD    = 8,
  parameter logic [2:0]  DEFAULT_SEL = 3'b000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] REQ,
  input  logic [4:0] LOCK,
  input  logic       READY,
  output logic [4:0] GNT,
  output logic [2:0] SELECT,
  output logic       VALID
);

  localparam int unsigned    HW         = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_LIMIT = HW'(MAX_HOLD);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_r;
  logic [2:0]    ptr_r;
  logic [HW-1:0] hold_r;
  logic [4:0]    gnt_r;
  logic [2:0]    sel_r;
  logic          valid_r;

  logic [2:0]    pick_s;
  logic [HW-1:0] hold_inc_s;
  logic          stay_s;
  logic          owner_req_s;

  // First requester after ptr, scanning ptr+1 .. ptr+5 modulo 5.
  function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idx = 3'((int'(ptr) + k) % 5);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [4:0] onehot5(input logic [2:0] idx);
    onehot5 = 5'(5'b00001 << idx);
  endfunction

  // While granted, ptr_r equals the owner, so one scan from ptr_r visits every other
  // requester before the owner itself -- that gives both the idle pick and the
  // release pick (others first, owner re-granted last).
  always_comb begin
    pick_s      = rr_pick(REQ, ptr_r);
    hold_inc_s  = hold_r + HW'(1);
    owner_req_s = REQ[ptr_r];
    stay_s      = LOCK[ptr_r] && (hold_inc_s < HOLD_LIMIT);
  end

  // Arbitration state machine with registered grant, select and valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      ptr_r   <= 3'd4;
      hold_r  <= '0;
      gnt_r   <= 5'b00000;
      sel_r   <= DEFAULT_SEL;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|REQ) begin
            state_r <= ST_GRANT;
            ptr_r   <= pick_s;
            hold_r  <= '0;
            gnt_r   <= onehot5(pick_s);
            sel_r   <= pick_s;
            valid_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            gnt_r   <= 5'b00000;
            sel_r   <= DEFAULT_SEL;
            valid_r <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!owner_req_s || (READY && !stay_s)) begin
            if (|REQ) begin
              state_r <= ST_GRANT;
              ptr_r   <= pick_s;
              hold_r  <= '0;
              gnt_r   <= onehot5(pick_s);
              sel_r   <= pick_s;
              valid_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              hold_r  <= '0;
              gnt_r   <= 5'b00000;
              sel_r   <= DEFAULT_SEL;
              valid_r <= 1'b0;
            end
          end else if (READY) begin
            hold_r <= hold_inc_s;
          end else begin
            hold_r <= hold_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ptr_r   <= 3'd4;
          hold_r  <= '0;
          gnt_r   <= 5'b00000;
          sel_r   <= DEFAULT_SEL;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign GNT    = gnt_r;
  assign SELECT = sel_r;
  assign VALID  = valid_r;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Bench for mux5_rr_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-free behavioural model (two parameter sets).
module tb_mux5_rr_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] REQ;
  logic [4:0] LOCK;
  logic       READY;

  logic [4:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       valid_a, valid_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: owner (-1 = idle), rr pointer, accepted beats of current owner.
  int own_a = -1, ptr_a = 4, hold_a = 0;
  int own_b = -1, ptr_b = 4, hold_b = 0;

  always #5 CLK = ~CLK;

  mux5_rr_arbiter #(.MAX_HOLD(8), .DEFAULT_SEL(3'b000)) dut_a (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .LOCK(LOCK), .READY(READY),
    .GNT(gnt_a), .SELECT(sel_a), .VALID(valid_a)
  );

  mux5_rr_arbiter #(.MAX_HOLD(1), .DEFAULT_SEL(3'b011)) dut_b (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .LOCK(LOCK), .READY(READY),
    .GNT(gnt_b), .SELECT(sel_b), .VALID(valid_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [4:0] req, input int from);
    for (int k = 1; k <= 5; k++)
      if (req[(from + k) % 5]) return (from + k) % 5;
    return -1;
  endfunction

  function automatic logic [4:0] exp_gnt(input int o);
    return (o < 0) ? 5'b00000 : 5'(5'b00001 << o);
  endfunction

  function automatic logic [2:0] exp_sel(input int o, input logic [2:0] dflt);
    return (o < 0) ? dflt : 3'(o);
  endfunction

  task automatic model_step(input int mh, input int own, input int ptr, input int hold,
                            output int n_own, output int n_ptr, output int n_hold);
    logic [4:0] others;
    bit         rel;
    n_own = own; n_ptr = ptr; n_hold = hold;
    if (own < 0) begin
      if (REQ != 5'b00000) begin
        n_own = pick(REQ, ptr); n_ptr = n_own; n_hold = 0;
      end
    end else begin
      rel = 1'b0;
      if (!REQ[own]) rel = 1'b1;
      else if (READY) begin
        if (LOCK[own] && (hold + 1 < mh)) n_hold = hold + 1;
        else rel = 1'b1;
      end
      if (rel) begin
        others = REQ;
        others[own] = 1'b0;
        if (others != 5'b00000) begin
          n_own = pick(others, own); n_ptr = n_own; n_hold = 0;
        end else if (REQ[own]) begin
          n_own = own; n_ptr = own; n_hold = 0;
        end else begin
          n_own = -1; n_ptr = own; n_hold = 0;
        end
      end
    end
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      own_a <= -1; ptr_a <= 4; hold_a <= 0;
      own_b <= -1; ptr_b <= 4; hold_b <= 0;
    end else begin : upd
      automatic int oa, pa, ha, ob, pb, hb;
      model_step(8, own_a, ptr_a, hold_a, oa, pa, ha);
      model_step(1, own_b, ptr_b, hold_b, ob, pb, hb);
      own_a <= oa; ptr_a <= pa; hold_a <= ha;
      own_b <= ob; ptr_b <= pb; hold_b <= hb;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_gnt_a",   32'(gnt_a),   32'(exp_gnt(own_a)));
      check("model_sel_a",   32'(sel_a),   32'(exp_sel(own_a, 3'b000)));
      check("model_valid_a", 32'(valid_a), 32'(own_a >= 0));
      check("model_gnt_b",   32'(gnt_b),   32'(exp_gnt(own_b)));
      check("model_sel_b",   32'(sel_b),   32'(exp_sel(own_b, 3'b011)));
      check("model_valid_b", 32'(valid_b), 32'(own_b >= 0));
    end
  end

  initial begin
    RESET = 1'b0; REQ = 5'b11111; LOCK = 5'b00000; READY = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_gnt",   32'(gnt_a),   32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_sel",   32'(sel_a),   32'h0);
    check("rst_sel_b", 32'(sel_b),   32'h3);
    RESET = 1'b1;
    @(negedge CLK);
    check("first_gnt", 32'(gnt_a), 32'h01);
    check("first_sel", 32'(sel_a), 32'h0);

    READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("fair_sel",   32'(sel_a),   32'((k + 1) % 5));
      check("fair_valid", 32'(valid_a), 32'h1);
    end

    REQ = 5'b00000; READY = 1'b0;
    @(negedge CLK);
    check("drain_valid", 32'(valid_a), 32'h0);
    REQ = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_gnt", 32'(gnt_a), 32'h08);
      check("bp_sel", 32'(sel_a), 32'h3);
    end
    READY = 1'b1;
    @(negedge CLK);
    check("bp_regrant", 32'(gnt_a), 32'h08);
    REQ = 5'b00000; READY = 1'b0;
    @(negedge CLK);
    check("bp_drop_valid", 32'(valid_a), 32'h0);

    REQ = 5'b00101; LOCK = 5'b00001; READY = 1'b1;
    @(negedge CLK);
    check("lock_grant", 32'(sel_a), 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      check("lock_hold", 32'(sel_a), 32'h0);
      if (i == 0) check("hold1_rotate_b", 32'(sel_b), 32'h2);
    end
    @(negedge CLK);
    check("lock_release_sel",   32'(sel_a),   32'h2);
    check("lock_release_valid", 32'(valid_a), 32'h1);

    REQ = 5'b10000; LOCK = 5'b00000; READY = 1'b0;
    @(negedge CLK);
    check("abort_gnt", 32'(gnt_a), 32'h10);
    check("abort_sel", 32'(sel_a), 32'h4);

    REQ = 5'b11111;
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("async_gnt",   32'(gnt_a),   32'h0);
    check("async_valid", 32'(valid_a), 32'h0);
    check("async_sel",   32'(sel_a),   32'h0);
    @(negedge CLK);
    #2 RESET = 1'b1;
    @(negedge CLK);
    check("async_ptr_gnt", 32'(gnt_a), 32'h01);

    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      REQ   = 5'($urandom);
      if ($urandom_range(0, 3) == 0) REQ = 5'b00000;
      LOCK  = 5'($urandom);
      READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 RESET = 1'b0;
        @(negedge CLK);
        #2 RESET = 1'b1;
      end
    end

    @(negedge CLK);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
